// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Takes one command byte via valid/ready and runs the request-to-send
// sequence on the open-drain clock/data pair: clock inhibit, start bit,
// 8 data bits LSB first, odd parity, stop, then checks the device ACK.
// The keyboard receiver beside this block must be gated with tx_busy.
// Optional build macro PS2_HOST_TX_RETRY_EN: one automatic retry of a
// failed transfer (timeout or NACK) before tx_err is reported.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // One counter serves both the inhibit hold and the edge timeout.
  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_NACK    = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_PARITY,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERR
`ifdef PS2_HOST_TX_RETRY_EN
    ,
    ST_RETRY
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        clk_sync, data_sync;
  logic              clk_prev;
  logic              clk_s, data_s;
  logic              fe, fe_act, in_link, timeout_hit;
  logic              accept;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        bit_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        data_q;
  logic              par_q;
  logic              fail;
  logic [1:0]        fail_code;
`ifdef PS2_HOST_TX_RETRY_EN
  logic              retry_used;
`endif

  assign clk_s   = clk_sync[1];
  assign data_s  = data_sync[1];
  assign fe      = clk_prev & ~clk_s;
  assign accept  = tx_valid & (state_q == ST_IDLE);
  assign bit_idx = 3'(bit_cnt - 4'd1);

  // Device edges only count while the host has released the clock.
  assign in_link = (state_q == ST_REQ) || (state_q == ST_SHIFT) ||
                   (state_q == ST_PARITY) || (state_q == ST_ACK) ||
                   (state_q == ST_WAIT_IDLE);
  assign fe_act      = fe & in_link;
  assign timeout_hit = in_link & (cnt_q == TO_LAST) & ~fe;

  // Pad synchronizers plus previous synchronized clock for edge detect.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
      clk_prev  <= clk_sync[1];
    end
  end

  // State register.
  always_ff @(posedge clk_100MHz) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic, including failure routing.
  always_comb begin
    state_d   = state_q;
    fail      = 1'b0;
    fail_code = 2'b00;
    case (state_q)
      ST_IDLE:      if (tx_valid) state_d = ST_INHIBIT;
      ST_INHIBIT:   if (cnt_q == INH_LAST) state_d = ST_REQ;
      ST_REQ:       if (fe_act) state_d = ST_SHIFT;
      ST_SHIFT:     if (fe_act && bit_cnt == 4'd8) state_d = ST_PARITY;
      ST_PARITY:    if (fe_act) state_d = ST_ACK;
      ST_ACK: begin
        if (fe_act) begin
          if (data_s) begin
            fail      = 1'b1;
            fail_code = CODE_NACK;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: if (clk_s && data_s) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      ST_ERR:       state_d = ST_IDLE;
`ifdef PS2_HOST_TX_RETRY_EN
      ST_RETRY:     if (cnt_q == INH_LAST) state_d = ST_INHIBIT;
`endif
      default:      state_d = ST_IDLE;
    endcase
    // A step completed in the same cycle takes precedence over the timeout.
    if (timeout_hit && state_d == state_q) begin
      fail      = 1'b1;
      fail_code = CODE_TIMEOUT;
    end
    if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
      state_d = retry_used ? ST_ERR : ST_RETRY;
`else
      state_d = ST_ERR;
`endif
    end
  end

  // Datapath: cycle counter, bit counter, latched byte, error code.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cnt_q    <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      err_code <= 2'b00;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_used <= 1'b0;
`endif
    end else begin
      if (state_q == ST_IDLE || state_d != state_q || fe_act)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 1'b1;

      if (accept) begin
        data_q  <= tx_data;
        par_q   <= ~^tx_data;
        bit_cnt <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_used <= 1'b0;
`endif
      end else if (fe_act && bit_cnt != 4'd11) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

`ifdef PS2_HOST_TX_RETRY_EN
      if (state_d == ST_RETRY && state_q != ST_RETRY) begin
        retry_used <= 1'b1;
        bit_cnt    <= '0;
      end
`endif

      if (state_d == ST_ERR && state_q != ST_ERR)
        err_code <= fail_code;
    end
  end

  // Outputs decoded from state; data line low means a 0 bit.
  always_comb begin
    tx_ready    = (state_q == ST_IDLE);
    tx_busy     = (state_q != ST_IDLE);
    tx_done     = (state_q == ST_DONE);
    tx_err      = (state_q == ST_ERR);
    ps2_clk_oe  = (state_q == ST_INHIBIT);
    ps2_data_oe = 1'b0;
    case (state_q)
      ST_INHIBIT: ps2_data_oe = (cnt_q == INH_LAST);
      ST_REQ:     ps2_data_oe = 1'b1;
      ST_SHIFT:   ps2_data_oe = ~data_q[bit_idx];
      ST_PARITY:  ps2_data_oe = ~par_q;
      default:    ps2_data_oe = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2
// device model driving the open-drain lines.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 300;
  localparam int          HALF = 10;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic [7:0] tx_data    = '0;
  logic       tx_valid   = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ps2_clk_oe  ? 1'b0 : dev_clk;
  assign ps2_data_line = ps2_data_oe ? 1'b0 : dev_data;

  int n_checks  = 0;
  int n_errs    = 0;
  int done_seen = 0;
  int err_seen  = 0;
  logic [1:0] exp_code = 2'b00;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .err_code   (err_code),
    .ps2_clk_i  (ps2_clk_line),
    .ps2_data_i (ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk_100MHz) begin
    if (tx_done) done_seen++;
    if (tx_err)  err_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  // Offer a byte and confirm the accept-cycle response; tx_valid is left high.
  task automatic start_tx(input string tag, input logic [7:0] b);
    int n;
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 400) begin cyc(1); n++; end
    cyc(1);
    check({tag, "_clkoe_rise"}, ps2_clk_oe, 1);
    check({tag, "_ready_fall"}, tx_ready, 0);
    check({tag, "_busy_rise"}, tx_busy, 1);
  endtask

  // Measure the clock-low hold and the data/clock overlap, then the start bit.
  task automatic wait_inhibit(input string tag);
    int n, hold, overlap;
    n = 0;
    while (!ps2_clk_oe && n < 1000) begin cyc(1); n++; end
    check({tag, "_inhibit_seen"}, ps2_clk_oe, 1);
    hold = 0;
    overlap = 0;
    while (ps2_clk_oe && hold < int'(INH) + 100) begin
      if (ps2_data_oe) overlap++;
      hold++;
      cyc(1);
    end
    check({tag, "_hold"}, hold, INH);
    check({tag, "_overlap"}, overlap, 1);
    check({tag, "_start"}, ps2_data_oe, 1);
  endtask

  // Device: generate clock pulses, sample the line before each rising edge.
  task automatic dev_frame(input int pulses, input bit ack,
                           output logic [10:0] bits, output int lat);
    bits = '0;
    lat  = 0;
    cyc(6);
    for (int k = 1; k <= pulses; k++) begin
      if (k == 11 && ack) begin
        dev_data = 1'b0;
        cyc(4);
      end
      dev_clk = 1'b0;
      for (int j = 1; j <= HALF; j++) begin
        cyc(1);
        if (k == 1 && lat == 0 && !ps2_data_oe) lat = j;
      end
      bits[k-1] = ps2_data_line;
      dev_clk = 1'b1;
      if (k == 11) dev_data = 1'b1;
      if (k < pulses) cyc(HALF);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!tx_ready && n < 400) begin cyc(1); n++; end
    check({tag, "_ready_back"}, tx_ready, 1);
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] b, input logic par);
    int d0, e0, lat;
    logic [10:0] bits;
    d0 = done_seen;
    e0 = err_seen;
    start_tx(tag, b);
    tx_valid = 1'b0;
    wait_inhibit(tag);
    dev_frame(11, 1'b1, bits, lat);
    check({tag, "_byte"}, bits[7:0], b);
    check({tag, "_parity"}, bits[8], par);
    check({tag, "_stop"}, bits[9], 1);
    if (b[0]) check({tag, "_latency"}, lat, 3);
    wait_ready(tag);
    check({tag, "_done_cnt"}, done_seen - d0, 1);
    check({tag, "_err_cnt"}, err_seen - e0, 0);
    check({tag, "_err_code"}, err_code, exp_code);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, c, n, lat;
    logic [10:0] bits;

    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    check("rst_clkoe", ps2_clk_oe, 0);
    check("rst_dataoe", ps2_data_oe, 0);
    check("rst_code", err_code, 0);

    run_xfer("x_ed", 8'hED, 1'b1);
    run_xfer("x_00", 8'h00, 1'b1);
    run_xfer("x_ff", 8'hFF, 1'b1);
    run_xfer("x_01", 8'h01, 1'b0);

    // Timeout: device never clocks after release.
    e0 = err_seen;
    d0 = done_seen;
    start_tx("tmo", 8'hF0);
    tx_valid = 1'b0;
    wait_inhibit("tmo");
    c = 0;
    while (!tx_err && c < 2 * int'(TMO) + 4 * int'(INH)) begin cyc(1); c++; end
`ifdef PS2_HOST_TX_RETRY_EN
    check("tmo_cycles", c, 2 * TMO + 2 * INH);
`else
    check("tmo_cycles", c, TMO);
`endif
    exp_code = 2'b01;
    check("tmo_code", err_code, 2'b01);
    check("tmo_clkoe", ps2_clk_oe, 0);
    check("tmo_dataoe", ps2_data_oe, 0);
    cyc(1);
    check("tmo_ready", tx_ready, 1);
    check("tmo_err_cnt", err_seen - e0, 1);
    check("tmo_done_cnt", done_seen - d0, 0);

    // NACK: device leaves data high on the ACK edge.
    e0 = err_seen;
    d0 = done_seen;
    start_tx("nack", 8'hFF);
    tx_valid = 1'b0;
    wait_inhibit("nack");
    dev_frame(11, 1'b0, bits, lat);
    check("nack_byte", bits[7:0], 8'hFF);
`ifdef PS2_HOST_TX_RETRY_EN
    wait_inhibit("retry");
    dev_frame(11, 1'b1, bits, lat);
    check("retry_byte", bits[7:0], 8'hFF);
    check("retry_parity", bits[8], 1);
    wait_ready("retry");
    check("retry_done_cnt", done_seen - d0, 1);
    check("retry_err_cnt", err_seen - e0, 0);
`else
    wait_ready("nack");
    exp_code = 2'b10;
    check("nack_code", err_code, 2'b10);
    check("nack_err_cnt", err_seen - e0, 1);
    check("nack_done_cnt", done_seen - d0, 0);
`endif

    // Reset after the fourth device clock edge.
    e0 = err_seen;
    d0 = done_seen;
    start_tx("rmid", 8'hED);
    tx_valid = 1'b0;
    wait_inhibit("rmid");
    dev_frame(4, 1'b1, bits, lat);
    reset = 1'b1;
    cyc(1);
    check("rmid_clkoe", ps2_clk_oe, 0);
    check("rmid_dataoe", ps2_data_oe, 0);
    check("rmid_ready", tx_ready, 1);
    reset = 1'b0;
    cyc(2);
    check("rmid_err_cnt", err_seen - e0, 0);
    check("rmid_done_cnt", done_seen - d0, 0);
    exp_code = 2'b00;
    check("rmid_code", err_code, 2'b00);
    run_xfer("x_after_rst", 8'h01, 1'b0);

    // tx_valid held through a whole transfer; tx_data changed mid-transfer.
    d0 = done_seen;
    start_tx("hold", 8'hA5);
    tx_data = 8'h3C;
    wait_inhibit("hold");
    dev_frame(11, 1'b1, bits, lat);
    check("hold_byte", bits[7:0], 8'hA5);
    check("hold_parity", bits[8], 1);
    n = 0;
    while (!tx_done && n < 200) begin cyc(1); n++; end
    check("hold_done", tx_done, 1);
    cyc(1);
    check("hold_ready_back", tx_ready, 1);
    cyc(1);
    check("hold_reaccept_clkoe", ps2_clk_oe, 1);
    check("hold_reaccept_busy", tx_busy, 1);
    tx_valid = 1'b0;
    wait_inhibit("hold2");
    dev_frame(11, 1'b1, bits, lat);
    check("hold2_byte", bits[7:0], 8'h3C);
    check("hold2_parity", bits[8], 1);
    wait_ready("hold2");
    check("hold_done_cnt", done_seen - d0, 2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
